// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the dual-lane fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] LANE_OFFSET      = 32'd4;
    localparam logic [31:0] PAIR_STRIDE      = 32'd8;

endpackage

// File: rtl/event_counter.sv
// rtl/event_counter.sv - wrapping event counter with synchronous active-low clear
module event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count enabled events; rolls over from all-ones to zero silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - lockstep boot/stall/redirect/flush control for the two-lane fetch stage
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_1,
    input  logic             stall_2,
    input  logic             branch_taken_1,
    input  logic             branch_taken_2,
    input  logic [31:0]      branch_target_1,
    input  logic [31:0]      branch_target_2,
    output logic             PC_reg_enable_1,
    output logic             PC_reg_enable_2,
    output logic             mux_PC_flag_1,
    output logic             mux_PC_flag_2,
    output logic [31:0]      jump_address_1,
    output logic [31:0]      jump_address_2,
    output logic             Readmem_1,
    output logic             Readmem_2,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             misalign_err
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    fetch_state_t state_q, state_d;
    logic [2:0]   fcnt_q, fcnt_d;
    logic         hold_q, hold_d;
    logic         mux_q, mux_d;
    logic         rd_q, rd_d;
    logic         flush_q, flush_d;
    logic [31:0]  ja1_q, ja1_d;
    logic [31:0]  ja2_q, ja2_d;
    logic         mis_q, mis_d;
    logic         redirect_inc;
    logic         stall_inc;
    logic         take_branch;
    logic [31:0]  raw_target;
    logic [31:0]  target;

    // Lane 1 is the older instruction, so it wins when both lanes resolve taken.
    assign take_branch = branch_taken_1 | branch_taken_2;
    assign raw_target  = branch_taken_1 ? branch_target_1 : branch_target_2;
    assign target      = {raw_target[31:2], 2'b00};

    // Next state and next registered outputs; both lanes share one set of control bits.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        hold_d       = 1'b0;
        mux_d        = 1'b0;
        rd_d         = 1'b1;
        flush_d      = 1'b0;
        ja1_d        = ja1_q;
        ja2_d        = ja2_q;
        mis_d        = mis_q;
        redirect_inc = 1'b0;
        stall_inc    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FLUSH;
                fcnt_d  = FLUSH_LOAD;
                mux_d   = 1'b1;
                rd_d    = 1'b0;
                flush_d = 1'b1;
                ja1_d   = RESET_PC;
                ja2_d   = RESET_PC + LANE_OFFSET;
            end
            FLUSH: begin
                // Branch and stall requests here come from wrong-path instructions.
                if (fcnt_q != 3'd0) begin
                    fcnt_d  = fcnt_q - 3'd1;
                    flush_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN, STALL: begin
                if (take_branch) begin
                    state_d      = FLUSH;
                    fcnt_d       = FLUSH_LOAD;
                    mux_d        = 1'b1;
                    flush_d      = 1'b1;
                    ja1_d        = target;
                    ja2_d        = target + LANE_OFFSET;
                    redirect_inc = 1'b1;
                    if (raw_target[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end
                end else if (stall_1 | stall_2) begin
                    state_d   = STALL;
                    hold_d    = 1'b1;
                    rd_d      = 1'b0;
                    stall_inc = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Output and state registers; reset parks the fetch stage holding with reads off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            fcnt_q  <= 3'd0;
            hold_q  <= 1'b1;
            mux_q   <= 1'b0;
            rd_q    <= 1'b0;
            flush_q <= 1'b0;
            ja1_q   <= 32'd0;
            ja2_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            hold_q  <= hold_d;
            mux_q   <= mux_d;
            rd_q    <= rd_d;
            flush_q <= flush_d;
            ja1_q   <= ja1_d;
            ja2_q   <= ja2_d;
            mis_q   <= mis_d;
        end
    end

    event_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_inc),
        .count (redirect_count)
    );

    event_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_count)
    );

    assign PC_reg_enable_1 = hold_q;
    assign PC_reg_enable_2 = hold_q;
    assign mux_PC_flag_1   = mux_q;
    assign mux_PC_flag_2   = mux_q;
    assign Readmem_1       = rd_q;
    assign Readmem_2       = rd_q;
    assign flush           = flush_q;
    assign jump_address_1  = ja1_q;
    assign jump_address_2  = ja2_q;
    assign misalign_err    = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int CNT_W = 4;
    localparam int VW    = 7 + 64 + 2 * CNT_W + 1;

    localparam int K_RST   = 0;
    localparam int K_BOOT  = 1;
    localparam int K_REDIR = 2;
    localparam int K_FLUSH = 3;
    localparam int K_RUN   = 4;
    localparam int K_STALL = 5;

    typedef struct {
        int            tag;
        logic [VW-1:0] v;
        string         nm;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             stall_1, stall_2;
    logic             branch_taken_1, branch_taken_2;
    logic [31:0]      branch_target_1, branch_target_2;
    logic             PC_reg_enable_1, PC_reg_enable_2;
    logic             mux_PC_flag_1, mux_PC_flag_2;
    logic [31:0]      jump_address_1, jump_address_2;
    logic             Readmem_1, Readmem_2;
    logic             flush;
    logic [CNT_W-1:0] redirect_count, stall_count;
    logic             misalign_err;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ej1    = 32'd0;
    logic [31:0] ej2    = 32'd0;
    logic [VW-1:0] act;

    fetch_sequencer #(
        .RESET_PC     (32'h0040_0000),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_1         (stall_1),
        .stall_2         (stall_2),
        .branch_taken_1  (branch_taken_1),
        .branch_taken_2  (branch_taken_2),
        .branch_target_1 (branch_target_1),
        .branch_target_2 (branch_target_2),
        .PC_reg_enable_1 (PC_reg_enable_1),
        .PC_reg_enable_2 (PC_reg_enable_2),
        .mux_PC_flag_1   (mux_PC_flag_1),
        .mux_PC_flag_2   (mux_PC_flag_2),
        .jump_address_1  (jump_address_1),
        .jump_address_2  (jump_address_2),
        .Readmem_1       (Readmem_1),
        .Readmem_2       (Readmem_2),
        .flush           (flush),
        .redirect_count  (redirect_count),
        .stall_count     (stall_count),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign act = {PC_reg_enable_1, PC_reg_enable_2, mux_PC_flag_1, mux_PC_flag_2,
                  Readmem_1, Readmem_2, flush, jump_address_1, jump_address_2,
                  redirect_count, stall_count, misalign_err};

    function automatic logic [VW-1:0] pack(input logic en, mux, rd, fl,
                                           input logic [31:0] j1, j2,
                                           input logic [CNT_W-1:0] rc, sc,
                                           input logic mis);
        return {en, en, mux, mux, rd, rd, fl, j1, j2, rc, sc, mis};
    endfunction

    // Drive one cycle of inputs and queue the outputs required for the cycle after the sampling edge.
    task automatic go(input logic r, s1, s2, b1, b2, input logic [31:0] t1, t2,
                      input int k, input logic [CNT_W-1:0] rc, sc, input logic mis,
                      input string nm);
        exp_t e;
        case (k)
            K_RST:   e.v = pack(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0, '0, 1'b0);
            K_BOOT:  e.v = pack(1'b0, 1'b1, 1'b0, 1'b1, ej1, ej2, rc, sc, mis);
            K_REDIR: e.v = pack(1'b0, 1'b1, 1'b1, 1'b1, ej1, ej2, rc, sc, mis);
            K_FLUSH: e.v = pack(1'b0, 1'b0, 1'b1, 1'b1, ej1, ej2, rc, sc, mis);
            K_RUN:   e.v = pack(1'b0, 1'b0, 1'b1, 1'b0, ej1, ej2, rc, sc, mis);
            default: e.v = pack(1'b1, 1'b0, 1'b0, 1'b0, ej1, ej2, rc, sc, mis);
        endcase
        e.tag = cyc + 1;
        e.nm  = nm;
        rst_n = r;
        stall_1 = s1;
        stall_2 = s2;
        branch_taken_1 = b1;
        branch_taken_2 = b2;
        branch_target_1 = t1;
        branch_target_2 = t2;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input logic [CNT_W-1:0] rc, sc, input logic mis,
                        input string nm);
        go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, k, rc, sc, mis, nm);
    endtask

    // Monitor: compare every queued expectation in the cycle it belongs to.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.tag != cyc || act !== mon_e.v) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %h required %h", mon_e.nm, cyc, act, mon_e.v);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        stall_1 = 1'b0;
        stall_2 = 1'b0;
        branch_taken_1 = 1'b0;
        branch_taken_2 = 1'b0;
        branch_target_1 = 32'd0;
        branch_target_2 = 32'd0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, K_RST, 4'd0, 4'd0, 1'b0, "reset_state");
        ej1 = 32'h0040_0000; ej2 = 32'h0040_0004;
        idle(K_BOOT, 4'd0, 4'd0, 1'b0, "boot_redirect");
        idle(K_FLUSH, 4'd0, 4'd0, 1'b0, "boot_flush_a");
        idle(K_FLUSH, 4'd0, 4'd0, 1'b0, "boot_flush_b");
        idle(K_RUN, 4'd0, 4'd0, 1'b0, "boot_run");

        for (int i = 1; i <= 4; i++)
            go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, K_STALL, 4'd0, 4'(i), 1'b0, "stall_hold");
        idle(K_RUN, 4'd0, 4'd4, 1'b0, "stall_release");

        ej1 = 32'h0040_0100; ej2 = 32'h0040_0104;
        go(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 32'h0040_0200, K_REDIR, 4'd1, 4'd4, 1'b0, "dual_branch");
        idle(K_FLUSH, 4'd1, 4'd4, 1'b0, "dual_flush_a");
        idle(K_FLUSH, 4'd1, 4'd4, 1'b0, "dual_flush_b");
        idle(K_RUN, 4'd1, 4'd4, 1'b0, "dual_run");

        ej1 = 32'h0040_0208; ej2 = 32'h0040_020C;
        go(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0040_0208, K_REDIR, 4'd2, 4'd4, 1'b0, "lane2_beats_stall");
        idle(K_FLUSH, 4'd2, 4'd4, 1'b0, "lane2_flush_a");
        idle(K_FLUSH, 4'd2, 4'd4, 1'b0, "lane2_flush_b");
        idle(K_RUN, 4'd2, 4'd4, 1'b0, "lane2_run");

        go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, K_STALL, 4'd2, 4'd5, 1'b0, "pre_branch_stall");
        ej1 = 32'h0040_0300; ej2 = 32'h0040_0304;
        go(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0300, 32'd0, K_REDIR, 4'd3, 4'd5, 1'b0, "branch_in_stall");
        go(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h0040_0400, K_FLUSH, 4'd3, 4'd5, 1'b0, "branch_in_flush_ignored");
        idle(K_FLUSH, 4'd3, 4'd5, 1'b0, "stall_flush_b");
        idle(K_RUN, 4'd3, 4'd5, 1'b0, "stall_branch_run");

        ej1 = 32'hFFFF_FFFC; ej2 = 32'h0000_0000;
        go(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0, K_REDIR, 4'd4, 4'd5, 1'b1, "misalign_wrap");
        idle(K_FLUSH, 4'd4, 4'd5, 1'b1, "misalign_flush_a");
        idle(K_FLUSH, 4'd4, 4'd5, 1'b1, "misalign_flush_b");
        idle(K_RUN, 4'd4, 4'd5, 1'b1, "misalign_sticky_a");
        idle(K_RUN, 4'd4, 4'd5, 1'b1, "misalign_sticky_b");

        ej1 = 32'h0040_0500; ej2 = 32'h0040_0504;
        go(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0500, 32'd0, K_REDIR, 4'd5, 4'd5, 1'b1, "pre_reset_redirect");
        idle(K_FLUSH, 4'd5, 4'd5, 1'b1, "pre_reset_flush");
        go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, K_RST, 4'd0, 4'd0, 1'b0, "reset_mid_flush");
        ej1 = 32'h0040_0000; ej2 = 32'h0040_0004;
        idle(K_BOOT, 4'd0, 4'd0, 1'b0, "reboot_redirect");
        idle(K_FLUSH, 4'd0, 4'd0, 1'b0, "reboot_flush_a");
        idle(K_FLUSH, 4'd0, 4'd0, 1'b0, "reboot_flush_b");
        idle(K_RUN, 4'd0, 4'd0, 1'b0, "reboot_run");

        for (int i = 1; i <= 17; i++)
            go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, K_STALL, 4'd0, 4'(i), 1'b0, "stall_count_wrap");
        idle(K_RUN, 4'd0, 4'd1, 1'b0, "wrap_release");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Dual-lane fetch controller sitting directly in front of the two-lane fetch stage. It drives the fetch stage's per-lane PC hold, PC-source select, jump target and memory-read controls. It boots both lanes to the reset vector, because the fetch PC registers have no reset of their own. At runtime it schedules lockstep stalls, branch redirects from either execute lane (lane 1 is older), and wrong-path flush windows, and keeps redirect/stall event counters.

## Interface
- RESET_PC, 32'h00400000, boot address; lane 1 boots to RESET_PC, lane 2 to RESET_PC+4
- FLUSH_CYCLES, 2, extra flush cycles after each redirect cycle (1..7)
- CNT_W, 16, width of event counters
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall_1, stall_2  in  1  decode-lane hazard requests; either one holds both lanes
- branch_taken_1, branch_taken_2  in  1  resolved taken branch/jump in execute lane 1 / 2
- branch_target_1, branch_target_2  in  32  targets for the matching taken flag
- PC_reg_enable_1, PC_reg_enable_2  out  1  PC hold to fetch; 1 = hold, 0 = load
- mux_PC_flag_1, mux_PC_flag_2  out  1  1 = load jump_address, 0 = load PC+8
- jump_address_1, jump_address_2  out  32  redirect PCs; lane 2 = lane 1 + 4
- Readmem_1, Readmem_2  out  1  instruction-memory read enables
- flush  out  1  kill both lanes' instructions in fetch/decode this cycle
- redirect_count  out  CNT_W  redirects issued since reset; wraps
- stall_count  out  CNT_W  cycles spent in STALL; wraps
- misalign_err  out  1  sticky; a taken target had bits [1:0] != 0

## Operation
- All outputs are registered. Inputs are sampled at edge E and drive outputs for the cycle after E. Fetch acts on those outputs at edge E+1.
- States: BOOT, RUN, STALL, FLUSH. Both lanes' control bits are always identical; there is no per-lane independent advance.
- Reset (rst_n=0 at an edge): state=BOOT. PC_reg_enable_*=1, mux_PC_flag_*=0, jump_address_*=0, Readmem_*=0, flush=0, counters=0, misalign_err=0, flush counter=0.
- BOOT is the first cycle after rst_n rises. It registers a redirect to RESET_PC / RESET_PC+4 with Readmem_*=0 and flush=1, then enters FLUSH. Boot does not increment redirect_count.
- Redirect: any sampled branch_taken_k in RUN or STALL.
  - Lane 1 wins if both are set.
  - Target T is the winner's target with bits [1:0] forced to 0. If the original bits [1:0] were nonzero, misalign_err is set.
  - The redirect cycle drives mux_PC_flag_*=1, jump_address_1=T, jump_address_2=T+4 (mod 2^32), PC_reg_enable_*=0, Readmem_*=1, flush=1.
  - redirect_count increments, and the flush counter loads FLUSH_CYCLES. Next state is FLUSH.
- FLUSH: flush=1, mux_PC_flag_*=0, PC_reg_enable_*=0, Readmem_*=1. The counter decrements each cycle; at 0 the state goes to RUN. branch_taken_* and stall_* are ignored in FLUSH because they are wrong-path.
- RUN: mux_PC_flag_*=0, PC_reg_enable_*=0, Readmem_*=1, flush=0.
  - Sampled stall_1|stall_2 with no branch goes to STALL.
  - A branch always beats a stall.
- STALL: PC_reg_enable_*=1, Readmem_*=0, flush=0, and stall_count increments each STALL cycle.
  - Stall deasserted goes to RUN.
  - A branch goes to the redirect cycle.
- A redirect is a single registered cycle between the sampling state and FLUSH. It is implemented as entry into FLUSH with the redirect outputs applied for that first cycle.
- rst_n low mid-operation (STALL, FLUSH, or redirect) returns to BOOT values at that edge. Any pending redirect is discarded.

## Timing
- Branch-to-target latency: branch_taken sampled at E, then redirect outputs in cycle E..E+1, then fetch PCs equal T/T+4 after E+1. The first target instruction is read in cycle E+1..E+2.
- flush is high for 1+FLUSH_CYCLES consecutive cycles per redirect.
- Stall-to-hold latency is 1 cycle. Release-to-advance latency is 1 cycle.
- Boot: rst_n rises before edge B. Redirect outputs hold during B..B+1. PCs equal RESET_PC/RESET_PC+4 after B+1.
- Counter wrap: all-ones + 1 = 0, with no flag.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (BOOT, RUN, STALL, FLUSH)
  - the default RESET_PC constant
  - the lane word offset 32'd4
  - the pair stride 32'd8
- Natural sub-module: event_counter (parameterized width, sync active-low clear, increment enable, wrap). It is instantiated twice.

## Test plan
- Boot: hold rst_n=0 for 3 cycles, then release. Required: one cycle with mux_PC_flag_*=1 and jump 00400000/00400004. flush is high for 3 cycles, then Readmem_*=1, enables 0, and redirect_count=0.
- Stall: in RUN, hold stall_2=1 for 4 cycles. Required: enables=1 and Readmem_*=0 for 4 cycles starting 1 cycle later, then stall_count=4 and resume.
- Dual branch: branch_taken_1 (target 00400100) and branch_taken_2 (target 00400200) in the same cycle. Required: jump_address_1=00400100, jump_address_2=00400104, and redirect_count=1.
- Branch during stall and flush: branch during STALL redirects. A second branch one cycle later, while in FLUSH, is ignored, so redirect_count rises by exactly 1.
- Misalign and wrap: target FFFFFFFE. Required: jump_address_1=FFFFFFFC, jump_address_2=00000000, and misalign_err stays 1 until reset.
- Reset mid-flush: drop rst_n in the 2nd FLUSH cycle. Required: all outputs at reset values next cycle, then a fresh BOOT sequence.
